// File: rtl/param_mod_counter.sv
// Parametrised modulo-N up/down counter with synchronous clear/load, wrap or
// saturate at the boundaries, a combinational terminal-count flag and a registered event pulse.
module param_mod_counter #(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MOD_MAX   = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE  = 1'b0,
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             evt
);

  localparam longint unsigned FULL_MAX = (64'd1 << WIDTH) - 64'd1;

  // Illegal parameter sets stop elaboration rather than silently misbehaving.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("param_mod_counter: WIDTH must be 1..32");
  end
  if (MOD_MAX == 64'd0 || MOD_MAX > FULL_MAX) begin : g_bad_mod_max
    $error("param_mod_counter: MOD_MAX must be 1..2**WIDTH-1");
  end
  if (RESET_VAL > MOD_MAX) begin : g_bad_reset_val
    $error("param_mod_counter: RESET_VAL must not exceed MOD_MAX");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             evt_q, evt_d;

  // tc doubles as the boundary detector: with en high it is exactly "next step crosses an end".
  assign tc = en & ((up & (q_q == MAX_Q)) | (~up & (q_q == '0)));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    q_d   = q_q;
    evt_d = tc & ~clr & ~load;
    if (clr) begin
      q_d = RST_Q;
    end else if (load) begin
      q_d = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (en) begin
      if (tc) begin
        q_d = SATURATE ? q_q : (up ? '0 : MAX_Q);
      end else begin
        q_d = up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst) begin
      q_q   <= RST_Q;
      evt_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      evt_q <= evt_d;
    end
  end

  assign q   = q_q;
  assign evt = evt_q;

endmodule

// File: tb/tb_param_mod_counter.sv
// Self-checking bench: three counter configurations (wrap, saturate, full 8-bit range)
// driven in lockstep and compared each cycle against an arithmetic reference model.
module tb_param_mod_counter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst, en, up, clr, load;
  logic [3:0] lv4;
  logic [7:0] lv8;
  logic [3:0] q_w, q_s;
  logic [7:0] q_f;
  logic       tc_w, tc_s, tc_f, evt_w, evt_s, evt_f;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: index 0 = wrap 0..10, 1 = saturate 0..10, 2 = wrap 0..255.
  int mmax [N] = '{10, 10, 255};
  bit msat [N] = '{1'b0, 1'b1, 1'b0};
  int mq   [N];
  int mev  [N];

  always #5 clk = ~clk;

  param_mod_counter #(.WIDTH(4), .MOD_MAX(10), .SATURATE(1'b0), .RESET_VAL(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv4), .q(q_w), .tc(tc_w), .evt(evt_w));

  param_mod_counter #(.WIDTH(4), .MOD_MAX(10), .SATURATE(1'b1), .RESET_VAL(0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv4), .q(q_s), .tc(tc_s), .evt(evt_s));

  param_mod_counter #(.WIDTH(8), .MOD_MAX(255), .SATURATE(1'b0), .RESET_VAL(0)) dut_f (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv8), .q(q_f), .tc(tc_f), .evt(evt_f));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_tc(input int i);
    if (!en) return 0;
    return up ? int'(mq[i] == mmax[i]) : int'(mq[i] == 0);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_q_w"},   32'(q_w),   32'(mq[0]));
    check({tag, "_q_s"},   32'(q_s),   32'(mq[1]));
    check({tag, "_q_f"},   32'(q_f),   32'(mq[2]));
    check({tag, "_evt_w"}, 32'(evt_w), 32'(mev[0]));
    check({tag, "_evt_s"}, 32'(evt_s), 32'(mev[1]));
    check({tag, "_evt_f"}, 32'(evt_f), 32'(mev[2]));
  endtask

  // One clock step: inputs were driven 1 ns after the previous edge.
  task automatic step(input string tag);
    int nq [N];
    int ne [N];
    int lv;
    #1;
    check({tag, "_tc_w"}, 32'(tc_w), 32'(model_tc(0)));
    check({tag, "_tc_s"}, 32'(tc_s), 32'(model_tc(1)));
    check({tag, "_tc_f"}, 32'(tc_f), 32'(model_tc(2)));
    for (int i = 0; i < N; i++) begin
      lv    = (i == 2) ? int'(lv8) : int'(lv4);
      nq[i] = mq[i];
      ne[i] = 0;
      if (!rst) begin
        nq[i] = 0;
      end else if (clr) begin
        nq[i] = 0;
      end else if (load) begin
        nq[i] = (lv > mmax[i]) ? mmax[i] : lv;
      end else if (en) begin
        if (model_tc(i) != 0) begin
          ne[i] = 1;
          if (!msat[i]) nq[i] = up ? 0 : mmax[i];
        end else begin
          nq[i] = up ? mq[i] + 1 : mq[i] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      mq[i]  = nq[i];
      mev[i] = ne[i];
    end
    check_outputs(tag);
  endtask

  task automatic load_all(input int v);
    clr = 1'b0; load = 1'b1; en = 1'b0;
    lv4 = 4'(v); lv8 = 8'(v);
    step("load");
    load = 1'b0;
  endtask

  initial begin
    int evt_cnt;
    rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; lv4 = '0; lv8 = '0;
    for (int i = 0; i < N; i++) begin mq[i] = 0; mev[i] = 0; end

    // Reset state, then release between edges.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("por");
    rst = 1'b1;

    // 1: asynchronous reset at q=7, then count 1,2,3 after release.
    load_all(7);
    check("s1_pre_q", 32'(q_w), 32'd7);
    #3;
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin mq[i] = 0; mev[i] = 0; end
    check_outputs("s1_async");
    #1;
    rst = 1'b1; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step("s1_cnt");
      check("s1_seq", 32'(q_w), 32'(k));
    end

    // 2: wrap up from 9.
    load_all(9);
    en = 1'b1; up = 1'b1;
    step("s2_a");
    check("s2_q10", 32'(q_w), 32'd10);
    step("s2_b");
    check("s2_wrap", 32'(q_w), 32'd0);
    check("s2_evt", 32'(evt_w), 32'd1);
    step("s2_c");
    check("s2_evt_drop", 32'(evt_w), 32'd0);

    // 3: wrap down from 1.
    load_all(1);
    en = 1'b1; up = 1'b0;
    step("s3_a");
    step("s3_b");
    check("s3_wrap", 32'(q_w), 32'd10);
    check("s3_evt", 32'(evt_w), 32'd1);
    step("s3_c");

    // 4: saturate at 10 for three cycles, then reverse.
    load_all(10);
    en = 1'b1; up = 1'b1;
    repeat (3) begin
      step("s4_hold");
      check("s4_q_sat", 32'(q_s), 32'd10);
      check("s4_evt_sat", 32'(evt_s), 32'd1);
    end
    up = 1'b0;
    step("s4_rev");
    check("s4_q_rev", 32'(q_s), 32'd9);
    check("s4_evt_rev", 32'(evt_s), 32'd0);

    // 5: clr beats load and en; an out-of-range load clamps.
    clr = 1'b1; load = 1'b1; lv4 = 4'd5; lv8 = 8'd5; en = 1'b1; up = 1'b1;
    step("s5_prio");
    check("s5_clr", 32'(q_w), 32'd0);
    clr = 1'b0; load = 1'b1; lv4 = 4'd15; lv8 = 8'd15;
    step("s5_clamp");
    check("s5_clamp_q", 32'(q_w), 32'd10);
    check("s5_clamp_evt", 32'(evt_w), 32'd0);
    load = 1'b0;

    // 6: full 8-bit range, 256 up-steps from 0.
    clr = 1'b1;
    step("s6_clr");
    clr = 1'b0; en = 1'b1; up = 1'b1;
    evt_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step("s6_run");
      if (evt_f === 1'b1) evt_cnt++;
    end
    check("s6_q_final", 32'(q_f), 32'd0);
    check("s6_evt_count", 32'(evt_cnt), 32'd1);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 31) == 0);
      load = ($urandom_range(0, 15) == 0);
      lv4  = 4'($urandom_range(0, 15));
      lv8  = 8'($urandom_range(0, 255));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
